// File: rtl/cga_text_writer.sv
// Terminal-style byte-stream writer for the 80x25 CGA text VRAM: control codes, cursor tracking, scroll by copy.
// One byte accepted per IDLE cycle; printable chars take 2 write cycles, clear takes 4000 cycles, scroll takes 7840 cycles.
module cga_text_writer #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 25,
  parameter logic [7:0] ATTR  = 8'h07,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic        clock_25,
  input  logic        reset,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [11:0] vram_address,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  input  logic [7:0]  vram_rdata,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y
);

  localparam logic [2:0] S_CLEAR    = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_WR_CHR   = 3'd2;
  localparam logic [2:0] S_WR_ATR   = 3'd3;
  localparam logic [2:0] S_SCR_RD   = 3'd4;
  localparam logic [2:0] S_SCR_WR   = 3'd5;
  localparam logic [2:0] S_SCR_FILL = 3'd6;

  localparam logic [11:0] LAST_BYTE = 12'(2 * COLS * ROWS - 1);
  localparam logic [11:0] COPY_LAST = 12'(2 * COLS * (ROWS - 1) - 1);
  localparam logic [11:0] ROW_BYTES = 12'(2 * COLS);
  localparam logic [6:0]  X_LAST    = 7'(COLS - 1);
  localparam logic [4:0]  Y_LAST    = 5'(ROWS - 1);

  logic [2:0]  state;
  logic [11:0] idx;
  logic [7:0]  chr;
  logic        run;
  logic [11:0] row_base;
  logic [11:0] cell_idx;
  logic [11:0] cell_addr;

  // y*80 as (y<<6)+(y<<4); the shift form assumes COLS=80.
  assign row_base  = ({7'd0, cursor_y} << 6) + ({7'd0, cursor_y} << 4);
  assign cell_idx  = row_base + {5'd0, cursor_x};
  assign cell_addr = {cell_idx[10:0], 1'b0};

  // run holds every output quiet during reset and the first cycle after release.
  always_comb begin
    char_ready   = 1'b0;
    vram_we      = 1'b0;
    vram_address = 12'd0;
    vram_wdata   = 8'd0;
    if (run) begin
      case (state)
        S_CLEAR, S_SCR_FILL: begin
          vram_we      = 1'b1;
          vram_address = idx;
          vram_wdata   = idx[0] ? ATTR : BLANK;
        end
        S_IDLE: char_ready = 1'b1;
        S_WR_CHR: begin
          vram_we      = 1'b1;
          vram_address = cell_addr;
          vram_wdata   = chr;
        end
        S_WR_ATR: begin
          vram_we      = 1'b1;
          vram_address = cell_addr | 12'd1;
          vram_wdata   = ATTR;
        end
        S_SCR_RD: vram_address = idx + ROW_BYTES;
        S_SCR_WR: begin
          vram_we      = 1'b1;
          vram_address = idx;
          vram_wdata   = vram_rdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      state    <= S_CLEAR;
      idx      <= 12'd0;
      chr      <= 8'd0;
      run      <= 1'b0;
      cursor_x <= 7'd0;
      cursor_y <= 5'd0;
    end else begin
      run <= 1'b1;
      if (run) begin
        case (state)
          S_CLEAR: begin
            if (idx == LAST_BYTE) begin
              idx      <= 12'd0;
              cursor_x <= 7'd0;
              cursor_y <= 5'd0;
              state    <= S_IDLE;
            end else begin
              idx <= idx + 12'd1;
            end
          end
          S_IDLE: begin
            if (char_valid) begin
              case (char_in)
                8'h0D: cursor_x <= 7'd0;
                8'h0A: begin
                  if (cursor_y < Y_LAST) begin
                    cursor_y <= cursor_y + 5'd1;
                  end else begin
                    idx   <= 12'd0;
                    state <= S_SCR_RD;
                  end
                end
                8'h08: if (cursor_x != 7'd0) cursor_x <= cursor_x - 7'd1;
                8'h0C: begin
                  idx   <= 12'd0;
                  state <= S_CLEAR;
                end
                default: begin
                  chr   <= char_in;
                  state <= S_WR_CHR;
                end
              endcase
            end
          end
          S_WR_CHR: state <= S_WR_ATR;
          S_WR_ATR: begin
            if (cursor_x < X_LAST) begin
              cursor_x <= cursor_x + 7'd1;
              state    <= S_IDLE;
            end else begin
              cursor_x <= 7'd0;
              if (cursor_y < Y_LAST) begin
                cursor_y <= cursor_y + 5'd1;
                state    <= S_IDLE;
              end else begin
                idx   <= 12'd0;
                state <= S_SCR_RD;
              end
            end
          end
          S_SCR_RD: state <= S_SCR_WR;
          // After the last copy idx lands on the first byte of the bottom row.
          S_SCR_WR: begin
            idx   <= idx + 12'd1;
            state <= (idx == COPY_LAST) ? S_SCR_FILL : S_SCR_RD;
          end
          S_SCR_FILL: begin
            if (idx == LAST_BYTE) begin
              idx      <= 12'd0;
              cursor_y <= Y_LAST;
              state    <= S_IDLE;
            end else begin
              idx <= idx + 12'd1;
            end
          end
          default: state <= S_CLEAR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cga_text_writer.sv
// Bench for cga_text_writer: expected VRAM writes are queued as stimulus is issued; a negedge monitor pops and compares.
module tb_cga_text_writer;

  logic        clock_25 = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  char_in = 8'd0;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [11:0] vram_address;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [7:0]  vram_rdata = 8'd0;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;

  cga_text_writer dut (
    .clock_25(clock_25), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .vram_address(vram_address), .vram_wdata(vram_wdata),
    .vram_we(vram_we), .vram_rdata(vram_rdata), .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  always #5 clock_25 = ~clock_25;

  typedef struct packed {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0] vram    [0:4095];
  logic [7:0] ref_mem [0:4095];
  wr_t        exp_q[$];
  int         checks = 0;
  int         passed = 0;
  int         wr_count = 0;
  int         tx = 0;
  int         ty = 0;

  // VRAM with one-cycle read latency
  always @(posedge clock_25) begin
    if (vram_we) vram[vram_address] <= vram_wdata;
    vram_rdata <= vram[vram_address];
  end

  always @(negedge clock_25) begin
    wr_t e;
    if (vram_we) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", vram_address, vram_wdata);
      end else begin
        e = exp_q.pop_front();
        if (vram_address == e.a && vram_wdata == e.d) passed++;
        else $display("FAIL vram_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                      vram_address, vram_wdata, e.a, e.d);
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic push(input int a, input logic [7:0] d);
    exp_q.push_back('{a: 12'(a), d: d});
    ref_mem[a] = d;
  endtask

  task automatic push_clear();
    for (int i = 0; i < 4000; i++) push(i, (i % 2 == 1) ? 8'h07 : 8'h20);
  endtask

  // Rows 1..24 move up one row, then the bottom row is blanked.
  task automatic push_scroll();
    for (int i = 0; i < 3840; i++) push(i, ref_mem[i + 160]);
    for (int i = 3840; i < 4000; i++) push(i, (i % 2 == 1) ? 8'h07 : 8'h20);
  endtask

  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (!char_ready && n < limit) begin
      @(posedge clock_25);
      #1;
      n++;
    end
    if (!char_ready) begin
      checks++;
      $display("FAIL ready_timeout: got char_ready=0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    wait_ready(20000, n);
    char_in    = b;
    char_valid = 1'b1;
    @(posedge clock_25);
    #1;
    char_valid = 1'b0;
  endtask

  task automatic send_print(input logic [7:0] c);
    push(2 * (ty * 80 + tx), c);
    push(2 * (ty * 80 + tx) + 1, 8'h07);
    if (tx < 79) tx++;
    else begin
      tx = 0;
      if (ty < 24) ty++;
      else push_scroll();
    end
    send(c);
  endtask

  task automatic send_lf();
    if (ty < 24) ty++;
    else push_scroll();
    send(8'h0A);
  endtask

  initial begin
    int n;
    int base;

    repeat (3) @(posedge clock_25);
    #1;
    check("reset_we", vram_we, 0);
    check("reset_ready", char_ready, 0);
    check("reset_addr", vram_address, 0);
    check("reset_wdata", vram_wdata, 0);
    check("reset_cx", cursor_x, 0);
    check("reset_cy", cursor_y, 0);

    push_clear();
    base = wr_count;
    reset = 1'b0;
    wait_ready(6000, n);
    check("clear_writes", wr_count - base, 4000);
    check("clear_cx", cursor_x, 0);
    check("clear_cy", cursor_y, 0);

    send_print(8'h41);
    wait_ready(20, n);
    check("A_ready_low_cycles", n, 2);
    check("A_cx", cursor_x, 1);
    check("A_cy", cursor_y, 0);

    send(8'h0D);
    tx = 0;
    check("cr_cx", cursor_x, 0);

    // One full row: last char lands at 158, attr at 159, cursor wraps to (0,1)
    for (int i = 0; i < 80; i++) send_print(8'(8'h21 + i));
    wait_ready(20, n);
    check("row_cx", cursor_x, 0);
    check("row_cy", cursor_y, 1);
    check("row_last_char", ref_mem[158], 8'(8'h21 + 79));

    base = wr_count;
    send(8'h0D);
    send(8'h08);
    check("bs_at_0_cx", cursor_x, 0);
    check("ctrl_writes_a", wr_count - base, 0);
    for (int i = 0; i < 5; i++) send_print(8'h61);
    wait_ready(20, n);
    check("five_cx", cursor_x, 5);
    base = wr_count;
    send(8'h08);
    tx = 4;
    check("bs_at_5_cx", cursor_x, 4);
    send_lf();
    send_lf();
    check("lf_cy3", cursor_y, 3);
    send_lf();
    check("lf_cy4", cursor_y, 4);
    check("ctrl_writes_b", wr_count - base, 0);

    for (int i = 0; i < 20; i++) send_lf();
    send(8'h0D);
    tx = 0;
    for (int i = 0; i < 79; i++) send_print(8'(8'h30 + (i % 10)));
    wait_ready(20, n);
    check("pre_scroll_cx", cursor_x, 79);
    check("pre_scroll_cy", cursor_y, 24);

    // 'Z' at 3998: 2 write cycles plus a 7840-cycle scroll before ready returns
    send_print(8'h5A);
    wait_ready(9000, n);
    check("scroll_ready_low_cycles", n, 7842);
    check("scroll_cx", cursor_x, 0);
    check("scroll_cy", cursor_y, 24);
    check("scroll_queue_drained", exp_q.size(), 0);

    push_clear();
    tx = 0;
    ty = 0;
    send(8'h0C);
    wait_ready(6000, n);
    check("ff_cx", cursor_x, 0);
    check("ff_cy", cursor_y, 0);
    check("ff_queue_drained", exp_q.size(), 0);

    for (int i = 0; i < 24; i++) send_lf();
    check("lf24_cy", cursor_y, 24);
    base = wr_count;
    send_lf();
    n = 0;
    while ((wr_count - base < 1000 || !vram_we) && n < 5000) begin
      @(posedge clock_25);
      #1;
      n++;
    end
    check("scroll_reached_1000", (wr_count - base >= 1000) ? 1 : 0, 1);
    reset = 1'b1;
    #1;
    check("abort_we", vram_we, 0);
    check("abort_ready", char_ready, 0);
    check("abort_cy", cursor_y, 0);
    exp_q.delete();
    repeat (2) @(posedge clock_25);
    #1;
    push_clear();
    tx = 0;
    ty = 0;
    base = wr_count;
    reset = 1'b0;
    wait_ready(6000, n);
    check("reclear_writes", wr_count - base, 4000);
    check("reclear_cx", cursor_x, 0);
    check("reclear_cy", cursor_y, 0);
    check("reclear_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
